// File: rtl/cla_sub_8bit_pipe.sv
// Two-stage pipelined subtractor: a - b - borrow computed as a + ~b + ~borrow with
// group carry lookahead; stage 1 resolves the low group, stage 2 the upper groups.
module cla_sub_8bit_pipe #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NG = WIDTH / GROUP;

    // Flat sum-of-products carries c[1..GROUP] of one group from its g/p and carry-in.
    function automatic logic [GROUP:1] grp_carry(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic cin);
        logic [GROUP:1] c;
        logic           term;
        c = '0;
        for (int i = 1; i <= GROUP; i++) begin
            term = cin;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    logic s1_en, s2_en;
    logic s1_valid_reg, s2_valid_reg;

    assign s2_en     = !s2_valid_reg || out_ready;
    assign s1_en     = !s1_valid_reg || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid_reg;

    // ---------------- stage 1 ----------------
    logic [WIDTH-1:0] in_bn, in_g, in_p;
    logic [GROUP:1]   in_gc;

    assign in_bn = ~in_b;
    assign in_g  = in_a & in_bn;
    assign in_p  = in_a ^ in_bn;
    assign in_gc = grp_carry(in_g[GROUP-1:0], in_p[GROUP-1:0], ~in_borrow);

    logic [WIDTH-1:0] s1_g_reg, s1_p_reg;
    logic [GROUP:0]   s1_c_reg;
    logic             s1_a_msb_reg, s1_bn_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_g_reg      <= '0;
            s1_p_reg      <= '0;
            s1_c_reg      <= '0;
            s1_a_msb_reg  <= 1'b0;
            s1_bn_msb_reg <= 1'b0;
        end else if (s1_en) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_g_reg      <= in_g;
                s1_p_reg      <= in_p;
                s1_c_reg      <= {in_gc, ~in_borrow};
                s1_a_msb_reg  <= in_a[WIDTH-1];
                s1_bn_msb_reg <= in_bn[WIDTH-1];
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [NG-1:1]        grp_g, grp_p, grp_cin;
    logic [WIDTH:GROUP+1] hi_c;
    logic [WIDTH:0]       c_all;
    logic [WIDTH-1:0]     diff;
    logic                 cin_term;

    generate
        for (genvar gi = 1; gi < NG; gi++) begin : g_grp
            logic [GROUP:1] gen_c;
            assign gen_c     = grp_carry(s1_g_reg[gi*GROUP +: GROUP], s1_p_reg[gi*GROUP +: GROUP], 1'b0);
            assign grp_g[gi] = gen_c[GROUP];
            assign grp_p[gi] = &s1_p_reg[gi*GROUP +: GROUP];
            assign hi_c[gi*GROUP+1 +: GROUP] =
                grp_carry(s1_g_reg[gi*GROUP +: GROUP], s1_p_reg[gi*GROUP +: GROUP], grp_cin[gi]);
        end
    endgenerate

    // Group carry-ins as sum-of-products over lower group G/P, seeded by group 0's carry out.
    always_comb begin
        grp_cin  = '0;
        cin_term = 1'b0;
        for (int k = 1; k < NG; k++) begin
            cin_term = s1_c_reg[GROUP];
            for (int j = 1; j < k; j++) cin_term = cin_term & grp_p[j];
            grp_cin[k] = cin_term;
            for (int j = 1; j < k; j++) begin
                cin_term = grp_g[j];
                for (int m = j + 1; m < k; m++) cin_term = cin_term & grp_p[m];
                grp_cin[k] = grp_cin[k] | cin_term;
            end
        end
    end

    assign c_all = {hi_c, s1_c_reg};
    assign diff  = s1_p_reg ^ c_all[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            out_diff     <= '0;
            out_borrow   <= 1'b0;
            out_ovf      <= 1'b0;
            out_zero     <= 1'b0;
        end else if (s2_en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_diff   <= diff;
                out_borrow <= ~c_all[WIDTH];
                out_ovf    <= (s1_a_msb_reg ^ ~s1_bn_msb_reg) & (diff[WIDTH-1] ^ s1_a_msb_reg);
                out_zero   <= (diff == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_sub_8bit_pipe.sv
// Self-checking bench: directed literal vectors, backpressure, streaming and reset
// scenarios checked against an arithmetic model with an in-order scoreboard.
module tb_cla_sub_8bit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_a, in_b, out_diff;
    logic       in_borrow, in_valid, in_ready;
    logic       out_borrow, out_ovf, out_zero, out_valid, out_ready;

    cla_sub_8bit_pipe #(.WIDTH(8), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .in_b(in_b), .in_borrow(in_borrow),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef logic [10:0] res_t;   // {diff, borrow, ovf, zero}

    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    res_t held;
    logic hold_v = 1'b0;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int         ud, sd;
        logic [7:0] d;
        ud = int'(a) - int'(b) - int'(bin);
        d  = ud[7:0];
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        return {d, 1'(ud < 0), 1'((sd < -128) || (sd > 127)), 1'(d == 8'h00)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t dut_res();
        return {out_diff, out_borrow, out_ovf, out_zero};
    endfunction

    // Scoreboard: every cycle, judged at the falling edge for the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(dut_res()), 32'(held));
            end
            if (q.size() == 0) chk("empty_no_valid", 32'(out_valid), 32'd0);
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            if (out_valid && out_ready && q.size() > 0) chk("result", 32'(dut_res()), 32'(q.pop_front()));
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_borrow));
            hold_v = out_valid && !out_ready;
            held   = dut_res();
        end
    end

    task automatic wait_accept();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_and_check(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  input res_t exp);
        chk("model_pin", 32'(model(a, b, bin)), 32'(exp));
        in_a = a; in_b = b; in_borrow = bin; in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        @(negedge clk); chk("lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat2_valid", 32'(out_valid), 32'd1);
        chk("literal", 32'(dut_res()), 32'(exp));
        $display("txn %02h - %02h - %0d -> diff %02h borrow %0d ovf %0d zero %0d",
                 a, b, bin, out_diff, out_borrow, out_ovf, out_zero);
        @(posedge clk); #1;
    endtask

    initial begin
        in_a = '0; in_b = '0; in_borrow = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(dut_res()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        send_and_check(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0, 1'b0});
        send_and_check(8'h03, 8'h05, 1'b0, {8'hFE, 1'b1, 1'b0, 1'b0});
        send_and_check(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1, 1'b0});
        send_and_check(8'h10, 8'h0F, 1'b1, {8'h00, 1'b0, 1'b0, 1'b1});
        send_and_check(8'h00, 8'hFF, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
        send_and_check(8'h00, 8'h00, 1'b0, {8'h00, 1'b0, 1'b0, 1'b1});
        send_and_check(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b1, 1'b0});

        // Backpressure: two fill the pipe, the third waits.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_a = 8'h0A + 8'(i); in_b = 8'h01; in_borrow = 1'b0; in_valid = 1'b1;
            wait_accept();
        end
        in_a = 8'h0C;
        @(negedge clk); chk("bp_full_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_diff", 32'(out_diff), 32'h09);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_order_valid", 32'(out_valid), 32'd1);
            chk("bp_order_diff", 32'(out_diff), 32'h09 + 32'(i));
            $display("txn drain %0d -> diff %02h", i, out_diff);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        repeat (2) @(posedge clk); #1;

        // Full-rate streaming: no bubbles.
        for (int i = 0; i < 20; i++) begin
            in_a = 8'(i * 37); in_b = 8'(i * 11 + 3); in_borrow = 1'(i); in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", 32'(in_ready), 32'd1);
            if (i >= 2) chk("stream_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Random traffic with random backpressure.
        for (int i = 0; i < 10000; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_borrow = 1'($urandom);
            in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;

        // Reset with two operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_a = 8'h40 + 8'(i); in_b = 8'h01; in_borrow = 1'b0; in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(dut_res()), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send_and_check(8'h20, 8'h21, 1'b0, {8'hFF, 1'b1, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
